// File: rtl/vending_pkg.sv
// Shared types and constants for the vending credit engine.
// Optional per-item stock tracking is enabled by defining VENDING_STOCK_EN.
package vending_pkg;

    // Controller modes: IDLE holds zero credit, CREDIT runs the wait timer,
    // RETURN pays change out one coin per cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        RETURN = 2'd2
    } state_e;

    localparam int DEF_NUM_COINS   = 3;
    localparam int DEF_NUM_ITEMS   = 4;
    localparam int DEF_TOTAL_BITS  = 31;
    localparam int DEF_WAIT_CYCLES = 100;
    localparam int DEF_STOCK_BITS  = 4;
    localparam int DEF_STOCK_INIT  = 5;

    // Smallest width (at least 1) that can hold the value max_val.
    function automatic int cnt_width(input int unsigned max_val);
        int w;
        w = 1;
        while ((longint'(1) << w) <= longint'(max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vending_credit_engine_if.sv
// Front-end / actuator bundle of the vending credit engine.
// The restock vector exists only when VENDING_STOCK_EN is defined.
interface vending_credit_engine_if
    import vending_pkg::*;
#(
    parameter int NUM_COINS  = DEF_NUM_COINS,
    parameter int NUM_ITEMS  = DEF_NUM_ITEMS,
    parameter int TOTAL_BITS = DEF_TOTAL_BITS
);

    logic [NUM_COINS-1:0]            i_input_coin;
    logic [NUM_ITEMS-1:0]            i_select_item;
    logic                            i_trigger_return;
    logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price;
    logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value;
`ifdef VENDING_STOCK_EN
    logic [NUM_ITEMS-1:0]            i_restock;
`endif
    logic [NUM_ITEMS-1:0]            o_available_item;
    logic [NUM_ITEMS-1:0]            o_output_item;
    logic [NUM_COINS-1:0]            o_return_coin;
    logic [TOTAL_BITS-1:0]           o_current_total;
    logic                            o_busy;

`ifdef VENDING_STOCK_EN
    // Front end / keypad side.
    modport master (
        output i_input_coin, i_select_item, i_trigger_return,
        output i_item_price, i_coin_value, i_restock,
        input  o_available_item, o_output_item, o_return_coin,
        input  o_current_total, o_busy
    );

    // Engine side.
    modport slave (
        input  i_input_coin, i_select_item, i_trigger_return,
        input  i_item_price, i_coin_value, i_restock,
        output o_available_item, o_output_item, o_return_coin,
        output o_current_total, o_busy
    );
`else
    // Front end / keypad side.
    modport master (
        output i_input_coin, i_select_item, i_trigger_return,
        output i_item_price, i_coin_value,
        input  o_available_item, o_output_item, o_return_coin,
        input  o_current_total, o_busy
    );

    // Engine side.
    modport slave (
        input  i_input_coin, i_select_item, i_trigger_return,
        input  i_item_price, i_coin_value,
        output o_available_item, o_output_item, o_return_coin,
        output o_current_total, o_busy
    );
`endif

endinterface

// File: rtl/vending_credit_engine_change_selector.sv
// Greedy change picker: the largest coin whose value does not exceed the
// remaining credit. Coin values are ascending with index, so the highest
// qualifying index is the largest coin.
module change_selector
    import vending_pkg::*;
#(
    parameter int NUM_COINS  = DEF_NUM_COINS,
    parameter int TOTAL_BITS = DEF_TOTAL_BITS
)(
    input  logic [TOTAL_BITS-1:0]           credit_i,
    input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value_i,
    output logic [NUM_COINS-1:0]            coin_onehot_o,
    output logic [TOTAL_BITS-1:0]           coin_val_o,
    output logic                            coin_hit_o
);

    // Scan upward; each qualifying coin overrides the smaller one before it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        coin_onehot_o = '0;
        coin_val_o    = '0;
        coin_hit_o    = 1'b0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_value_i[i*TOTAL_BITS +: TOTAL_BITS] <= credit_i) begin
                coin_onehot_o    = '0;
                coin_onehot_o[i] = 1'b1;
                coin_val_o       = coin_value_i[i*TOTAL_BITS +: TOTAL_BITS];
                coin_hit_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_credit_engine.sv
// Vending credit engine: accumulates coin credit, vends one item per accepted
// selection, times out idle credit and pays change back greedily.
// Define VENDING_STOCK_EN to add per-item stock counters and i_restock.
module vending_credit_engine
    import vending_pkg::*;
#(
    parameter int NUM_COINS   = DEF_NUM_COINS,
    parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
    parameter int TOTAL_BITS  = DEF_TOTAL_BITS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int STOCK_BITS  = DEF_STOCK_BITS,
    parameter int STOCK_INIT  = DEF_STOCK_INIT
)(
    input  logic                   clk,
    input  logic                   reset,
    vending_credit_engine_if.slave bus
);

    localparam int TIMER_W = cnt_width(WAIT_CYCLES);
    // Wide enough for credit plus every coin inserted at once.
    localparam int SUM_W   = TOTAL_BITS + cnt_width(NUM_COINS);
    localparam logic [TOTAL_BITS-1:0] CREDIT_MAX   = '1;
    localparam logic [TIMER_W-1:0]    TIMER_RELOAD = TIMER_W'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [TOTAL_BITS-1:0] credit_q, credit_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [NUM_ITEMS-1:0]  vend_q, vend_d;

    logic [TOTAL_BITS-1:0] price [NUM_ITEMS];
    logic [TOTAL_BITS-1:0] min_coin;
    logic [NUM_ITEMS-1:0]  in_stock;
    logic [NUM_ITEMS-1:0]  affordable;
    logic [NUM_ITEMS-1:0]  sel_first;
    logic [NUM_ITEMS-1:0]  accept_vec;
    logic [TOTAL_BITS-1:0] accept_price;
    logic [TOTAL_BITS-1:0] spent;
    logic [SUM_W-1:0]      coin_sum;
    logic [SUM_W-1:0]      credit_ext;
    logic [TOTAL_BITS-1:0] credit_upd;
    logic                  trigger_hit;
    logic                  vend_take;
    logic                  activity;

    logic [NUM_COINS-1:0]  change_onehot;
    logic [TOTAL_BITS-1:0] change_val;
    logic [TOTAL_BITS-1:0] change_rem;
    logic                  change_hit;

    // Unpack the flat price vector into one word per item.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            price[i] = bus.i_item_price[i*TOTAL_BITS +: TOTAL_BITS];
        end
    end

    // Coin 0 is the smallest denomination; anything below it cannot be paid out.
    assign min_coin = bus.i_coin_value[TOTAL_BITS-1:0];

`ifdef VENDING_STOCK_EN
    logic [STOCK_BITS-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_BITS-1:0] stock_d [NUM_ITEMS];

    // An item with an empty counter can be neither shown nor sold.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            in_stock[i] = (stock_q[i] != '0);
        end
    end

    // Restock overrides a vend of the same item in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (bus.i_restock[i]) begin
                stock_d[i] = STOCK_BITS'(STOCK_INIT);
            end else if (vend_d[i]) begin
                stock_d[i] = stock_q[i] - STOCK_BITS'(1);
            end
        end
    end

    // Stock counters register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this register array is reset element by element; its contents are live state, not scratch storage.
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_BITS'(STOCK_INIT);
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end
`else
    // Unlimited stock: every item is always in stock.
    assign in_stock = '1;

    logic unused_stock_cfg;
    assign unused_stock_cfg = (STOCK_BITS > 0) ^ (STOCK_INIT > 0);
`endif

    // An item is affordable against the registered (pre-coin) credit.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            affordable[i] = (credit_q >= price[i]) && in_stock[i];
        end
    end

    // Lowest-index selection wins; the rest are ignored.
    always_comb begin
        logic found;
        found     = 1'b0;
        sel_first = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (bus.i_select_item[i] && !found) begin
                sel_first[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign accept_vec = sel_first & affordable;

    // Price of the accepted item (accept_vec is at most one-hot).
    always_comb begin
        accept_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (accept_vec[i]) begin
                accept_price = accept_price | price[i];
            end
        end
    end

    // Total value of all coins inserted this cycle.
    always_comb begin
        coin_sum = '0;
        for (int c = 0; c < NUM_COINS; c++) begin
            if (bus.i_input_coin[c]) begin
                coin_sum = coin_sum + SUM_W'(bus.i_coin_value[c*TOTAL_BITS +: TOTAL_BITS]);
            end
        end
    end

    // A return request in CREDIT pre-empts any same-cycle selection.
    assign trigger_hit = (state_q == CREDIT) && bus.i_trigger_return;
    assign vend_take   = (|accept_vec) && !trigger_hit && (state_q != RETURN);
    assign activity    = vend_take || (|bus.i_input_coin);
    assign spent       = vend_take ? accept_price : '0;

    // Credit after this cycle's vend and coins, saturating at the register maximum.
    assign credit_ext = SUM_W'(credit_q) - SUM_W'(spent) + coin_sum;
    assign credit_upd = (|credit_ext[SUM_W-1:TOTAL_BITS]) ? CREDIT_MAX
                                                          : credit_ext[TOTAL_BITS-1:0];

    change_selector #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_change_selector (
        .credit_i      (credit_q),
        .coin_value_i  (bus.i_coin_value),
        .coin_onehot_o (change_onehot),
        .coin_val_o    (change_val),
        .coin_hit_o    (change_hit)
    );

    assign change_rem = credit_q - change_val;

    // Next-state logic for mode, credit, wait timer and vend pulse.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        vend_d   = '0;
        case (state_q)
            IDLE, CREDIT: begin
                credit_d = credit_upd;
                if (vend_take) begin
                    vend_d = accept_vec;
                end
                if (trigger_hit) begin
                    state_d = RETURN;
                    timer_d = '0;
                end else if (activity) begin
                    state_d = CREDIT;
                    timer_d = TIMER_RELOAD;
                end else if (state_q == CREDIT) begin
                    if (timer_q == '0) begin
                        state_d = RETURN;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end
            RETURN: begin
                timer_d = '0;
                // Keep paying while a coin still fits after this one; a
                // residual below the smallest coin is forfeited.
                if (change_hit && (change_rem != '0) && (change_rem >= min_coin)) begin
                    credit_d = change_rem;
                end else begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
                timer_d  = '0;
            end
        endcase
    end

    // Engine state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            timer_q  <= '0;
            vend_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            vend_q   <= vend_d;
        end
    end

    // Moore outputs: all derived from registered state.
    assign bus.o_available_item = (state_q != RETURN) ? affordable : '0;
    assign bus.o_output_item    = vend_q;
    assign bus.o_return_coin    = (state_q == RETURN) ? change_onehot : '0;
    assign bus.o_current_total  = credit_q;
    assign bus.o_busy           = (state_q == RETURN);

endmodule

// File: doc/vending_credit_engine.md
# vending_credit_engine

Parametrised successor to the lab vending-machine datapath. It tracks inserted credit, vends one item per selection when credit suffices, and runs a wait-time timeout. On timeout or on request it dispenses change as a cycle-by-cycle greedy sequence of coins. It sits between the coin/keypad front end and the dispenser actuators, with all state in one registered FSM.

## Interface
- NUM_COINS, 3, number of coin denominations
- NUM_ITEMS, 4, number of vendable items
- TOTAL_BITS, 31, width of credit registers
- WAIT_CYCLES, 100, idle cycles in CREDIT before automatic return (≥1)
- STOCK_BITS, 4, per-item stock counter width (used only with VENDING_STOCK_EN)
- STOCK_INIT, 5, stock value loaded at reset and on restock
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_input_coin  in  NUM_COINS  one bit per denomination inserted this cycle
- i_select_item  in  NUM_ITEMS  item selection request
- i_trigger_return  in  1  request change return
- i_item_price  in  NUM_ITEMS*TOTAL_BITS  flat price vector, item i at bits [i*TOTAL_BITS +: TOTAL_BITS]
- i_coin_value  in  NUM_COINS*TOTAL_BITS  flat coin values, strictly ascending with index
- i_restock  in  NUM_ITEMS  reload stock (present only with VENDING_STOCK_EN)
- o_available_item  out  NUM_ITEMS  item affordable (and in stock) now
- o_output_item  out  NUM_ITEMS  one-hot vend pulse
- o_return_coin  out  NUM_COINS  one-hot change coin pulse
- o_current_total  out  TOTAL_BITS  registered credit
- o_busy  out  1  high in RETURN; front end rejects coins

## Operation
- States: IDLE (credit 0), CREDIT, RETURN. Reset → IDLE, credit 0, timer 0, all outputs 0.
- IDLE/CREDIT, each cycle: coin_sum = Σ value of asserted i_input_coin bits; multiple bits add together.
- Selection: lowest-index asserted i_select_item bit wins; others ignored. It is accepted iff registered credit ≥ price (and stock > 0 when enabled).
- Next credit = credit − (accepted price or 0) + coin_sum, saturating at 2^TOTAL_BITS−1. Selection is judged against pre-coin credit.
- An accepted vend or any coin reloads the timer to WAIT_CYCLES and moves to CREDIT. Otherwise, in CREDIT, the timer decrements.
- CREDIT → RETURN when the timer reaches 0 or i_trigger_return=1. The trigger has priority over a same-cycle selection, and that selection is dropped. Coins in the trigger cycle are still credited.
- IDLE with the trigger: no action. A rejected selection does not reload the timer.
- RETURN: o_return_coin is one-hot for the largest coin with value ≤ credit, and credit decreases by that value each cycle. Inputs are ignored.
- RETURN ends when credit = 0, or when credit < smallest coin (residual cleared), then → IDLE.
- o_available_item[i] = (state != RETURN) && credit ≥ price[i] (&& stock[i] > 0).

## Timing
- Coin at edge n → o_current_total updated after edge n.
- Accepted select at edge n → o_output_item high exactly one cycle, n to n+1.
- Trigger at edge n → RETURN from n+1. The first o_return_coin is valid in that cycle (Moore output), one coin per cycle after that.
- Timeout: last activity at edge n → RETURN entered at edge n+WAIT_CYCLES+1.
- Reset asserted mid-operation → outputs 0 immediately. No pending coins are returned.

## Configuration
- VENDING_STOCK_EN defined: per-item STOCK_BITS counters load STOCK_INIT at reset. They decrement on vend and reload on i_restock[i]. Restock and vend in the same cycle: restock wins. An item at 0 is unavailable and its selection is rejected.
- Undefined: unlimited stock, no counters, no i_restock port.

## Structure
- vending_pkg: state enum (IDLE, CREDIT, RETURN), default parameter constants, width helper.
- Sub-module change_selector: combinational greedy pick of the largest coin ≤ credit, returning a one-hot and its value.

## Test plan
Defaults unless stated; coins 100/500/1000; prices 400/500/1000/2000; WAIT_CYCLES=10.
- Insert 500 → total 500 next cycle, o_available_item=0011. Select item1 → o_output_item=0010 for one cycle, total 0.
- Insert 1000+500 in the same cycle → total 1500. Trigger → o_return_coin 100 (1000) then 010 (500), then IDLE, total 0.
- Insert 100, then no activity → o_return_coin=001 on the 11th cycle after the insert edge, then IDLE.
- Total 500, select items 0 and 3 together → item0 vends, total 100. Select 3 with trigger → no vend, return 100.
- Reset asserted mid-RETURN (total 1000) → all outputs 0 immediately, IDLE after release.
- VENDING_STOCK_EN, STOCK_INIT=1: vend item0 twice with credit 800 → second rejected, bit0 available=0. i_restock[0] → available again.
